// File: rtl/operand_fetch_pkg.sv
// Shared widths, register types and the execute-side payload for the operand-fetch stage.
package operand_fetch_pkg;

    localparam int unsigned AWIDTH  = 3;
    localparam int unsigned DWIDTH  = 8;
    localparam int unsigned OPWIDTH = 4;
    localparam int unsigned NREGS   = 1 << AWIDTH;

    typedef logic [AWIDTH-1:0]  reg_addr_t;
    typedef logic [DWIDTH-1:0]  reg_data_t;
    typedef logic [OPWIDTH-1:0] op_t;

    typedef struct packed {
        op_t       op;
        reg_data_t op1;
        reg_data_t op2;
        reg_addr_t rd;
        logic      rd_we;
    } ex_bundle_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decoder, register-bank, writeback and execute signals of the operand-fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic      id_valid;
    logic      id_ready;
    op_t       id_op;
    reg_addr_t id_rs1;
    reg_addr_t id_rs2;
    reg_addr_t id_rd;
    logic      id_rd_we;

    reg_addr_t raddr1;
    reg_addr_t raddr2;
    reg_data_t rdata1;
    reg_data_t rdata2;

    logic      wb_wen;
    reg_addr_t wb_waddr;
    reg_data_t wb_wdata;

    logic      ex_valid;
    logic      ex_ready;
    op_t       ex_op;
    reg_data_t ex_op1;
    reg_data_t ex_op2;
    reg_addr_t ex_rd;
    logic      ex_rd_we;

    // Environment side: decoder, register bank, writeback and execute.
    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, id_rd_we,
        input  id_ready,
        input  raddr1, raddr2,
        output rdata1, rdata2,
        output wb_wen, wb_waddr, wb_wdata,
        input  ex_valid, ex_op, ex_op1, ex_op2, ex_rd, ex_rd_we,
        output ex_ready
    );

    // Operand-fetch stage side.
    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, id_rd_we,
        output id_ready,
        output raddr1, raddr2,
        input  rdata1, rdata2,
        input  wb_wen, wb_waddr, wb_wdata,
        output ex_valid, ex_op, ex_op1, ex_op2, ex_rd, ex_rd_we,
        input  ex_ready
    );

endinterface

// File: rtl/operand_scoreboard.sv
// Pending-write bit per register with set/clear and three pend lookups.
// OPERAND_FORWARD_EN: a register being cleared this cycle already reads as not pending.
module operand_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en,
    input  reg_addr_t set_idx,
    input  logic      clr_en,
    input  reg_addr_t clr_idx,
    input  reg_addr_t idx_a,
    input  reg_addr_t idx_b,
    input  reg_addr_t idx_c,
    output logic      pend_a_c,
    output logic      pend_b_c,
    output logic      pend_c_c
);

    logic [NREGS-1:0] pending_q;

    function automatic logic lookup(input reg_addr_t idx);
`ifdef OPERAND_FORWARD_EN
        return (idx != '0) && pending_q[idx] && !(clr_en && (clr_idx == idx));
`else
        return (idx != '0) && pending_q[idx];
`endif
    endfunction

    assign pend_a_c = lookup(idx_a);
    assign pend_b_c = lookup(idx_b);
    assign pend_c_c = lookup(idx_c);

    // Set is applied after clear so a new writer wins over the retiring one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            if (clr_en) pending_q[clr_idx] <= 1'b0;
            if (set_en) pending_q[set_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: bank read, writeback forwarding, hazard stall and execute output register.
// OPERAND_FORWARD_EN: forward same-cycle writeback data and release RAW stalls one cycle earlier.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    logic       wb_any_c;
    logic       pend_rs1_c;
    logic       pend_rs2_c;
    logic       pend_rd_c;
    logic       hazard_c;
    logic       slot_free_c;
    logic       accept_c;
    logic       set_en_c;
    reg_data_t  op1_c;
    reg_data_t  op2_c;
    logic       ex_valid_q;
    ex_bundle_t ex_q;

    assign bus.raddr1 = bus.id_rs1;
    assign bus.raddr2 = bus.id_rs2;

    // Writes to x0 never touch the scoreboard or the forwarding path.
    assign wb_any_c = bus.wb_wen && (bus.wb_waddr != '0);

    operand_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en_c),
        .set_idx  (bus.id_rd),
        .clr_en   (wb_any_c),
        .clr_idx  (bus.wb_waddr),
        .idx_a    (bus.id_rs1),
        .idx_b    (bus.id_rs2),
        .idx_c    (bus.id_rd),
        .pend_a_c (pend_rs1_c),
        .pend_b_c (pend_rs2_c),
        .pend_c_c (pend_rd_c)
    );

    assign hazard_c    = pend_rs1_c || pend_rs2_c ||
                         (bus.id_rd_we && (bus.id_rd != '0) && pend_rd_c);
    assign slot_free_c = !ex_valid_q || bus.ex_ready;
    assign bus.id_ready = slot_free_c && !hazard_c;
    assign accept_c    = bus.id_valid && slot_free_c && !hazard_c;
    assign set_en_c    = accept_c && bus.id_rd_we && (bus.id_rd != '0);

`ifdef OPERAND_FORWARD_EN
    assign op1_c = (wb_any_c && (bus.wb_waddr == bus.id_rs1)) ? bus.wb_wdata : bus.rdata1;
    assign op2_c = (wb_any_c && (bus.wb_waddr == bus.id_rs2)) ? bus.wb_wdata : bus.rdata2;
`else
    logic unused_wdata_c;
    assign unused_wdata_c = ^bus.wb_wdata;
    assign op1_c = bus.rdata1;
    assign op2_c = bus.rdata2;
`endif

    // Output register: load on accept, drain on ex_ready, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (accept_c) begin
            ex_valid_q <= 1'b1;
            ex_q.op    <= bus.id_op;
            ex_q.op1   <= op1_c;
            ex_q.op2   <= op2_c;
            ex_q.rd    <= bus.id_rd;
            ex_q.rd_we <= bus.id_rd_we && (bus.id_rd != '0);
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_op    = ex_q.op;
    assign bus.ex_op1   = ex_q.op1;
    assign bus.ex_op2   = ex_q.op2;
    assign bus.ex_rd    = ex_q.rd;
    assign bus.ex_rd_we = ex_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard scenarios plus random traffic against a scoreboard model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register bank: combinational read, written by writeback just after each edge.
    reg_data_t regs [NREGS];
    assign bus.rdata1 = regs[bus.raddr1];
    assign bus.rdata2 = regs[bus.raddr2];

    bit         m_pend [NREGS];
    logic       m_valid;
    ex_bundle_t m_ex;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hit(input reg_addr_t r);
        return bus.wb_wen && (bus.wb_waddr == r) && (r != '0);
    endfunction

    function automatic bit pend(input reg_addr_t r);
`ifdef OPERAND_FORWARD_EN
        return m_pend[r] && !wb_hit(r);
`else
        return m_pend[r];
`endif
    endfunction

    function automatic reg_data_t operand(input reg_addr_t r);
        reg_data_t v;
        v = (r == '0) ? '0 : regs[r];
`ifdef OPERAND_FORWARD_EN
        if (wb_hit(r)) v = bus.wb_wdata;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_ex    = '0;
    endtask

    task automatic issue(input logic v, input int op, input int rs1, input int rs2,
                         input int rd, input logic we);
        bus.id_valid = v;
        bus.id_op    = op_t'(op);
        bus.id_rs1   = reg_addr_t'(rs1);
        bus.id_rs2   = reg_addr_t'(rs2);
        bus.id_rd    = reg_addr_t'(rd);
        bus.id_rd_we = we;
    endtask

    task automatic wb(input logic en, input int addr, input int data);
        bus.wb_wen   = en;
        bus.wb_waddr = reg_addr_t'(addr);
        bus.wb_wdata = reg_data_t'(data);
    endtask

    // One clock: predict from the current inputs, check, apply the edge to model and bank.
    task automatic cycle(input string tag);
        bit         hz, rdy, acc, wbh, exr;
        reg_addr_t  wba;
        reg_data_t  wbd;
        ex_bundle_t nxt;
        hz  = pend(bus.id_rs1) || pend(bus.id_rs2) ||
              (bus.id_rd_we && (bus.id_rd != '0) && pend(bus.id_rd));
        rdy = (!m_valid || bus.ex_ready) && !hz;
        acc = bus.id_valid && rdy;
        exr = bus.ex_ready;
        wbh = bus.wb_wen && (bus.wb_waddr != '0);
        wba = bus.wb_waddr;
        wbd = bus.wb_wdata;
        nxt.op    = bus.id_op;
        nxt.op1   = operand(bus.id_rs1);
        nxt.op2   = operand(bus.id_rs2);
        nxt.rd    = bus.id_rd;
        nxt.rd_we = bus.id_rd_we && (bus.id_rd != '0);
        #1;
        check({tag, ".id_ready"}, 32'(bus.id_ready), 32'(rdy));
        check({tag, ".raddr1"}, 32'(bus.raddr1), 32'(bus.id_rs1));
        check({tag, ".raddr2"}, 32'(bus.raddr2), 32'(bus.id_rs2));
        @(posedge clk);
        #1;
        if (wbh) begin
            m_pend[wba] = 1'b0;
            regs[wba]   = wbd;
        end
        if (acc && nxt.rd_we) m_pend[nxt.rd] = 1'b1;
        if (acc) begin
            m_valid = 1'b1;
            m_ex    = nxt;
        end else if (exr) begin
            m_valid = 1'b0;
        end
        check({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(m_valid));
        check({tag, ".ex_op"},    32'(bus.ex_op),    32'(m_ex.op));
        check({tag, ".ex_op1"},   32'(bus.ex_op1),   32'(m_ex.op1));
        check({tag, ".ex_op2"},   32'(bus.ex_op2),   32'(m_ex.op2));
        check({tag, ".ex_rd"},    32'(bus.ex_rd),    32'(m_ex.rd));
        check({tag, ".ex_rd_we"}, 32'(bus.ex_rd_we), 32'(m_ex.rd_we));
    endtask

    initial begin
        reg_addr_t pq [$];
        rst_n = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) regs[i] = '0;
        regs[1] = 8'h05;
        regs[2] = 8'h07;
        issue(1'b0, 0, 0, 0, 0, 1'b0);
        wb(1'b0, 0, 0);
        bus.ex_ready = 1'b1;
        model_reset();

        #2;
        check("reset.ex_valid", 32'(bus.ex_valid), 32'd0);
        check("reset.ex_op1",   32'(bus.ex_op1),   32'd0);
        check("reset.ex_rd_we", 32'(bus.ex_rd_we), 32'd0);
        check("reset.id_ready", 32'(bus.id_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Independent stream at full throughput
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, i, 1, 2, 6, 1'b0);
            cycle("indep");
            check("indep.op1_const", 32'(bus.ex_op1), 32'h05);
            check("indep.op2_const", 32'(bus.ex_op2), 32'h07);
        end

        // Back-pressure holds the output register and blocks the decoder
        bus.ex_ready = 1'b0;
        issue(1'b1, 9, 2, 1, 6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp");
            check("bp.hold_op", 32'(bus.ex_op), 32'd3);
        end
        bus.ex_ready = 1'b1;
        cycle("bp_release");
        check("bp.load_op",  32'(bus.ex_op),  32'd9);
        check("bp.load_op1", 32'(bus.ex_op1), 32'h07);

        // RAW on x3
        issue(1'b1, 1, 0, 0, 3, 1'b1);
        cycle("raw_writer");
        issue(1'b1, 2, 3, 0, 5, 1'b0);
        cycle("raw_stall");
        check("raw.stalled", 32'(bus.id_ready), 32'd0);
        wb(1'b1, 3, 8'h2A);
        cycle("raw_wb");
`ifdef OPERAND_FORWARD_EN
        check("raw.fwd_op",  32'(bus.ex_op),  32'd2);
        check("raw.fwd_op1", 32'(bus.ex_op1), 32'h2A);
        wb(1'b0, 0, 0);
        issue(1'b0, 0, 0, 0, 0, 1'b0);
`else
        wb(1'b0, 0, 0);
        cycle("raw_late");
        check("raw.late_op",  32'(bus.ex_op),  32'd2);
        check("raw.late_op1", 32'(bus.ex_op1), 32'h2A);
        issue(1'b0, 0, 0, 0, 0, 1'b0);
`endif
        cycle("raw_idle");

        // WAW on x4, then x4 stays pending for the second writer
        issue(1'b1, 3, 0, 0, 4, 1'b1);
        cycle("waw_first");
        issue(1'b1, 4, 0, 0, 4, 1'b1);
        cycle("waw_stall");
        check("waw.stalled", 32'(bus.id_ready), 32'd0);
        wb(1'b1, 4, 8'h11);
        cycle("waw_wb");
        wb(1'b0, 0, 0);
`ifndef OPERAND_FORWARD_EN
        cycle("waw_late");
`endif
        check("waw.second_op", 32'(bus.ex_op), 32'd4);
        issue(1'b1, 5, 4, 0, 0, 1'b0);
        cycle("waw_pending");
        check("waw.still_pending", 32'(bus.id_ready), 32'd0);
        wb(1'b1, 4, 8'h22);
        cycle("waw_wb2");
        wb(1'b0, 0, 0);
        cycle("waw_after");
        issue(1'b0, 0, 0, 0, 0, 1'b0);
        cycle("waw_idle");

        // x0 is never a destination or a forwarding source
        issue(1'b1, 6, 0, 0, 0, 1'b1);
        cycle("x0_write");
        check("x0.rd_we", 32'(bus.ex_rd_we), 32'd0);
        issue(1'b1, 7, 0, 0, 2, 1'b0);
        wb(1'b1, 0, 8'hFF);
        cycle("x0_read");
        check("x0.op",  32'(bus.ex_op),  32'd7);
        check("x0.op1", 32'(bus.ex_op1), 32'd0);
        wb(1'b0, 0, 0);
        issue(1'b0, 0, 0, 0, 0, 1'b0);
        cycle("x0_idle");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            issue(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            pq.delete();
            for (int i = 1; i < int'(NREGS); i++) if (m_pend[i]) pq.push_back(reg_addr_t'(i));
            if (pq.size() > 0 && $urandom_range(0, 1) == 1)
                wb(1'b1, int'(pq[$urandom_range(0, pq.size() - 1)]), int'($urandom_range(0, 255)));
            else
                wb($urandom_range(0, 7) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            cycle("rand");
        end

        // Reset in the middle of an operation
        wb(1'b0, 0, 0);
        bus.ex_ready = 1'b1;
        issue(1'b1, 8, 0, 0, 5, 1'b1);
        bus.ex_ready = 1'b0;
        cycle("rst_setup");
        issue(1'b0, 0, 0, 0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst.ex_rd",    32'(bus.ex_rd),    32'd0);
        check("rst.ex_rd_we", 32'(bus.ex_rd_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;
        issue(1'b1, 9, 5, 0, 0, 1'b0);
        cycle("rst_reissue");
        check("rst.reissue_valid", 32'(bus.ex_valid), 32'd1);
        check("rst.reissue_op",    32'(bus.ex_op),    32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage between the decoder and execute.
- Drives the two read ports of the register bank and forwards the writeback value being written in the same cycle.
- Tracks outstanding register writes in a scoreboard and stalls on RAW/WAW hazards.
- Delivers operands to execute through a valid/ready output register.

Parameters:
AWIDTH, 3, register address width; 2**AWIDTH architectural registers, x0 hardwired zero
DWIDTH, 8, register data width
OPWIDTH, 4, opaque decoded-operation field passed through to execute

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decoder presents an instruction
id_ready  out  1  stage accepts the instruction this cycle
id_op  in  OPWIDTH  decoded operation, passed through
id_rs1  in  AWIDTH  source register 1
id_rs2  in  AWIDTH  source register 2
id_rd  in  AWIDTH  destination register
id_rd_we  in  1  instruction writes id_rd
raddr1  out  AWIDTH  register bank read address 1, equals id_rs1 combinationally
raddr2  out  AWIDTH  register bank read address 2, equals id_rs2 combinationally
rdata1  in  DWIDTH  register bank read data 1 (combinational)
rdata2  in  DWIDTH  register bank read data 2 (combinational)
wb_wen  in  1  writeback write enable (same signal driving the bank)
wb_waddr  in  AWIDTH  writeback address
wb_wdata  in  DWIDTH  writeback data
ex_valid  out  1  operands valid to execute
ex_ready  in  1  execute accepts
ex_op  out  OPWIDTH  registered op
ex_op1  out  DWIDTH  registered operand 1
ex_op2  out  DWIDTH  registered operand 2
ex_rd  out  AWIDTH  registered destination
ex_rd_we  out  1  registered write flag, forced 0 when rd==0

Behaviour:
- Reset (async, rst_n low): ex_valid=0, ex_op/op1/op2/rd=0, ex_rd_we=0, scoreboard all clear. Reset mid-operation discards the in-flight instruction and all pending bits.
- wb_hit(r) = wb_wen && wb_waddr==r && r!=0.
- pend(r) = scoreboard[r] && !wb_hit(r). x0 is never pending.
- Hazard:
  - RAW: pend(id_rs1) or pend(id_rs2).
  - WAW: id_rd_we && id_rd!=0 && pend(id_rd).
- Output register free: slot_free = !ex_valid || ex_ready.
- id_ready = slot_free && !hazard. id_ready is combinational and must not depend on id_valid.
- Accept = id_valid && id_ready:
  - Output register loads op, rd, rd_we&&(rd!=0).
  - op1 = wb_hit(rs1) ? wb_wdata : rdata1; op2 likewise.
  - Single-cycle latency: accepted at edge N, ex_valid high after edge N.
- Hold: while ex_valid && !ex_ready, all ex_* outputs stay stable.
- ex_valid clears on ex_ready with no accept. Back-to-back accepts are allowed: full throughput with no hazards.
- Scoreboard update per edge:
  - Clear bit wb_waddr on wb_hit.
  - Set bit id_rd on accept with rd_we && rd!=0.
  - Set wins on same index, which only arises after WAW clearance in the same cycle.
- wb_hit on a non-pending register is legal: just clears nothing.
- Only one outstanding writer per register, guaranteed by the WAW stall.

Optional Feature:
OPERAND_FORWARD_EN
- Defined: forwarding as above; a RAW source cleared by wb_hit in the same cycle does not stall.
- Undefined:
  - pend(r) = scoreboard[r] (no wb_hit term); operands are always rdata1/rdata2.
  - A dependent instruction issues the cycle after the writeback edge.
  - Costs one extra stall cycle per dependency.

Decomposition:
- Package operand_fetch_pkg: default AWIDTH/DWIDTH/OPWIDTH constants, typedef reg_addr_t, typedef reg_data_t, and a struct for the ex_* bundle.
- Sub-module operand_scoreboard: pending bit-vector with set/clear ports and the pend lookup for three indices.
- Top level holds forwarding muxes, handshake and output register.

Test Plan:
- Independent stream: x1=5, x2=7 preloaded; issue rs1=1, rs2=2 each cycle with ex_ready=1 -> ex_op1=5, ex_op2=7 every cycle, id_ready never drops.
- Back-pressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0; on ex_ready=1 next instruction loads next edge.
- RAW with forward: issue rd=3 we; next cycle issue rs1=3 (stalls, id_ready=0); when wb_wen=1, wb_waddr=3, wb_wdata=0x2A -> accepted that cycle, ex_op1=0x2A. Without OPERAND_FORWARD_EN -> accepted one cycle later, op1 from rdata1=0x2A.
- WAW: two back-to-back instructions with rd=4 -> second stalls until wb_hit(4); pending[4] remains set after that edge.
- x0: rd=0 we=1 then rs1=0 -> no stall, ex_rd_we=0, ex_op1=0 even with wb_wen=1, wb_waddr=0, wb_wdata=0xFF.
- Reset mid-operation: pending[5] set and ex_valid=1, assert rst_n=0 -> ex_valid=0 immediately, rs1=5 then issues without stall.
